mf_output_capture: RTL and testbench

MF_OUTPUT_CAPTURE -- requirements
Module: mf_output_capture

---
 rtl/mf_output_capture.sv | 163 ++++++++++++++++
 tb/tb_mf_output_capture.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mf_output_capture.sv
// mf_output_capture: captures a burst of complex matched-filter output samples
// into a RAM, then plays them back in order on request.
//
// Optional feature: define MF_CAPTURE_ABS_EN to store the saturated absolute
// value of each component instead of the raw sample. Capture and playback
// timing is the same in both builds.
module mf_output_capture #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  dataValid,
    input  logic [DATA_WIDTH-1:0] dataInRe,
    input  logic [DATA_WIDTH-1:0] dataInIm,
    input  logic                  readEnable,
    output logic [DATA_WIDTH-1:0] dataOutRe,
    output logic [DATA_WIDTH-1:0] dataOutIm,
    output logic                  dataOutValid,
    output logic                  captureFullFlag,
    output logic                  dataFinishedFlag,
    output logic [ADDR_WIDTH:0]   sampleCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_FULL,
        S_PLAYBACK,
        S_STOP
    } state_t;

    // Count value just before the write that fills the RAM.
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [ADDR_WIDTH:0]     rd_ptr_q, rd_ptr_d;
    logic                    wr_en;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   out_re_q, out_im_q;
    logic                    out_vld_q;

    logic [DATA_WIDTH-1:0]   mem_re [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_im [DEPTH];

    // The write pointer always equals the number of samples stored so far,
    // and capture stops before the count can exceed DEPTH, so the low bits
    // of the count serve as the write address.
    assign wr_addr = count_q[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    // Value written to the RAM for one component.
    function automatic logic [DATA_WIDTH-1:0] store_val(input logic [DATA_WIDTH-1:0] x);
`ifdef MF_CAPTURE_ABS_EN
        if (!x[DATA_WIDTH-1]) begin
            return x;
        end else if (x == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
            // Most negative value has no positive twin: saturate.
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            return -x;
        end
`else
        return x;
`endif
    endfunction

    // Next-state, counter and RAM strobe decode.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_CAPTURE;
                    count_d = '0;
                end
            end
            S_CAPTURE: begin
                if (dataValid) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                end
                // A sample arriving with the enable drop is still written.
                if (!enable || (dataValid && count_q == LAST_IDX)) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (readEnable) begin
                    state_d  = S_PLAYBACK;
                    rd_ptr_d = '0;
                end
            end
            S_PLAYBACK: begin
                // One address per cycle; the extra cycle after the last issue
                // lets the final registered sample be presented before STOP.
                if (rd_ptr_q < count_q) begin
                    rd_en    = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Capture RAM write port; contents are never reset.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem_re[wr_addr] <= store_val(dataInRe);
            mem_im[wr_addr] <= store_val(dataInIm);
        end
    end

    // Synchronous RAM read straight into the output register; zero when idle.
    always_ff @(posedge clock) begin
        if (reset || !rd_en) begin
            out_re_q  <= '0;
            out_im_q  <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_re_q  <= mem_re[rd_addr];
            out_im_q  <= mem_im[rd_addr];
            out_vld_q <= 1'b1;
        end
    end

    assign dataOutRe        = out_re_q;
    assign dataOutIm        = out_im_q;
    assign dataOutValid     = out_vld_q;
    assign captureFullFlag  = (state_q == S_FULL) || (state_q == S_PLAYBACK) || (state_q == S_STOP);
    assign dataFinishedFlag = (state_q == S_STOP);
    assign sampleCount      = count_q;

endmodule

// File: tb/tb_mf_output_capture.sv
// Self-checking bench for mf_output_capture. Stored contents are modelled as a
// queue of the first DEPTH accepted samples; playback must reproduce it.
module tb_mf_output_capture;

    localparam int DEPTH = 1024;
    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int SMAX  = (1 << (DW - 1)) - 1;

    logic          clock = 1'b0;
    logic          reset, enable, dataValid, readEnable;
    logic [DW-1:0] dataInRe, dataInIm, dataOutRe, dataOutIm;
    logic          dataOutValid, captureFullFlag, dataFinishedFlag;
    logic [AW:0]   sampleCount;

    int n_cmp = 0;
    int n_err = 0;
    int exp_re[$];
    int exp_im[$];
    int first_re, first_im;

    typedef struct {
        int n;
        bit drop_last;
        int gap_pct;
        int exp_count;
    } vec_t;

    always #5 clock = ~clock;

    mf_output_capture #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .dataValid       (dataValid),
        .dataInRe        (dataInRe),
        .dataInIm        (dataInIm),
        .readEnable      (readEnable),
        .dataOutRe       (dataOutRe),
        .dataOutIm       (dataOutIm),
        .dataOutValid    (dataOutValid),
        .captureFullFlag (captureFullFlag),
        .dataFinishedFlag(dataFinishedFlag),
        .sampleCount     (sampleCount)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // What the RAM should hold for an input component.
    function automatic int model_store(input int v);
        int r = v;
`ifdef MF_CAPTURE_ABS_EN
        if (r < 0) r = -r;
        if (r > SMAX) r = SMAX;
`endif
        return r;
    endfunction

    // Sample generator: 0 random, 1 ramp n/-n, 2 signed corner values.
    function automatic int gen(input int mode, input int i, input bit im);
        if (mode == 1) return im ? -i : i;
        if (mode == 2) begin
            case (i % 3)
                0:       return im ? -5 : -(SMAX + 1);
                1:       return im ? -SMAX : SMAX;
                default: return im ? -1 : 0;
            endcase
        end
        return int'($urandom_range(0, 2 * SMAX + 1)) - (SMAX + 1);
    endfunction

    // Start from IDLE, offer n valid samples (with random gaps), and end in FULL.
    task automatic do_capture(input int n, input bit drop_last, input int gap_pct,
                              input int mode, input bit hold_re);
        int sent = 0;
        int v_re, v_im;
        bit v;
        bit dropped = 1'b0;
        exp_re.delete();
        exp_im.delete();
        enable = 1'b1;
        tick();
        chk("cap_entry_count", sampleCount, 0);
        chk("cap_entry_full", captureFullFlag, 0);
        while (sent < n) begin
            v    = ($urandom_range(0, 99) >= gap_pct);
            v_re = gen(mode, sent, 1'b0);
            v_im = gen(mode, sent, 1'b1);
            dataValid  = v;
            dataInRe   = v_re[DW-1:0];
            dataInIm   = v_im[DW-1:0];
            readEnable = hold_re;
            if (v) begin
                if (exp_re.size() < DEPTH && !dropped) begin
                    exp_re.push_back(model_store(v_re));
                    exp_im.push_back(model_store(v_im));
                end
                sent++;
                if (sent == n && drop_last) begin
                    enable  = 1'b0;
                    dropped = 1'b1;
                end
            end
            tick();
            chk("cap_count", sampleCount, exp_re.size());
            chk("cap_full", captureFullFlag, (exp_re.size() == DEPTH || dropped) ? 1 : 0);
            chk("cap_outvalid", dataOutValid, 0);
        end
        dataValid  = 1'b0;
        readEnable = 1'b0;
        if (!dropped && exp_re.size() < DEPTH) begin
            enable = 1'b0;
            tick();
        end
        tick();
        chk("cap_done_full", captureFullFlag, 1);
        chk("cap_done_count", sampleCount, exp_re.size());
        chk("cap_done_fin", dataFinishedFlag, 0);
    endtask

    // From FULL: request playback, check latency, data, STOP and return to IDLE.
    task automatic do_playback();
        int n = exp_re.size();
        readEnable = 1'b1;
        tick();
        readEnable = 1'b0;
        chk("pb_lat_valid", dataOutValid, 0);
        chk("pb_lat_re", $signed(dataOutRe), 0);
        chk("pb_lat_fin", dataFinishedFlag, 0);
        chk("pb_lat_full", captureFullFlag, 1);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("pb_valid", dataOutValid, 1);
            chk("pb_re", $signed(dataOutRe), exp_re[i]);
            chk("pb_im", $signed(dataOutIm), exp_im[i]);
            chk("pb_fin", dataFinishedFlag, 0);
            if (i == 0) begin
                first_re = int'($signed(dataOutRe));
                first_im = int'($signed(dataOutIm));
            end
        end
        tick();
        chk("pb_end_valid", dataOutValid, 0);
        chk("pb_end_re", $signed(dataOutRe), 0);
        chk("pb_end_im", $signed(dataOutIm), 0);
        chk("pb_end_fin", dataFinishedFlag, 1);
        chk("pb_end_full", captureFullFlag, 1);
        chk("pb_end_count", sampleCount, n);
        if (enable) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("stop_hold_fin", dataFinishedFlag, 1);
            end
            enable = 1'b0;
        end
        tick();
        chk("idle_fin", dataFinishedFlag, 0);
        chk("idle_full", captureFullFlag, 0);
        chk("idle_count_kept", sampleCount, n);
    endtask

    initial begin
        vec_t tbl[7];
        tbl[0] = '{5,    1'b1, 0,  5};
        tbl[1] = '{0,    1'b0, 0,  0};
        tbl[2] = '{1,    1'b0, 0,  1};
        tbl[3] = '{17,   1'b0, 40, 17};
        tbl[4] = '{3,    1'b1, 50, 3};
        tbl[5] = '{1030, 1'b0, 10, 1024};
        tbl[6] = '{1024, 1'b1, 0,  1024};

        reset = 1'b1; enable = 1'b0; dataValid = 1'b0; readEnable = 1'b0;
        dataInRe = '0; dataInIm = '0;
        tick(); tick();
        chk("rst_valid", dataOutValid, 0);
        chk("rst_re", $signed(dataOutRe), 0);
        chk("rst_im", $signed(dataOutIm), 0);
        chk("rst_full", captureFullFlag, 0);
        chk("rst_fin", dataFinishedFlag, 0);
        chk("rst_count", sampleCount, 0);
        reset = 1'b0;
        tick();

        // Full-depth ramp; the 1025th sample must be dropped.
        do_capture(1025, 1'b0, 0, 1, 1'b0);
        chk("ramp_count", sampleCount, 1024);
        do_playback();

        for (int i = 0; i < 7; i++) begin
            do_capture(tbl[i].n, tbl[i].drop_last, tbl[i].gap_pct, 0, 1'b0);
            chk("tbl_count", sampleCount, tbl[i].exp_count);
            do_playback();
        end

        // Signed corner values through the storage path.
        do_capture(3, 1'b0, 0, 2, 1'b0);
        do_playback();
`ifdef MF_CAPTURE_ABS_EN
        chk("corner_re", first_re, 32767);
        chk("corner_im", first_im, 5);
`else
        chk("corner_re", first_re, -32768);
        chk("corner_im", first_im, -5);
`endif

        // readEnable during CAPTURE, dataValid during FULL: both ignored.
        do_capture(6, 1'b0, 30, 0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            dataValid = 1'b1;
            dataInRe  = DW'($urandom);
            dataInIm  = DW'($urandom);
            tick();
            chk("full_noise_count", sampleCount, 6);
            chk("full_noise_full", captureFullFlag, 1);
            chk("full_noise_valid", dataOutValid, 0);
            chk("full_noise_fin", dataFinishedFlag, 0);
        end
        dataValid = 1'b0;
        do_playback();

        // Reset on the third playback output cycle.
        do_capture(8, 1'b0, 0, 0, 1'b0);
        readEnable = 1'b1;
        tick();
        readEnable = 1'b0;
        tick(); tick(); tick();
        chk("rpb_pre_valid", dataOutValid, 1);
        chk("rpb_pre_re", $signed(dataOutRe), exp_re[2]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rpb_valid", dataOutValid, 0);
        chk("rpb_re", $signed(dataOutRe), 0);
        chk("rpb_im", $signed(dataOutIm), 0);
        chk("rpb_full", captureFullFlag, 0);
        chk("rpb_fin", dataFinishedFlag, 0);
        chk("rpb_count", sampleCount, 0);
        readEnable = 1'b1;
        tick();
        readEnable = 1'b0;
        chk("rpb_idle_full", captureFullFlag, 0);
        chk("rpb_idle_valid", dataOutValid, 0);
        do_capture(4, 1'b1, 0, 0, 1'b0);
        do_playback();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
